// File: rtl/wallace_mult_pipe.sv
// Three-stage pipelined Wallace-tree multiplier, WIDTH x WIDTH -> 2*WIDTH, unsigned or signed per operand pair.
// Define WALLACE_TAG_EN to add an in_tag/out_tag sideband that travels in lockstep with each product.
module wallace_mult_pipe #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product
`ifdef WALLACE_TAG_EN
  ,
  input  logic [TAG_W-1:0]   in_tag,
  output logic [TAG_W-1:0]   out_tag
`endif
);

  localparam int PW         = 2 * WIDTH;
  localparam int NR         = WIDTH + 1;
  localparam int MAX_LAYERS = 10;

  if (WIDTH < 4 || WIDTH > 32) begin : g_bad_width
    $error("wallace_mult_pipe: WIDTH must be in 4..32");
  end

  // Handshake: a transfer happens on every edge where valid && ready, on both
  // ports. A stage advances when it is empty or the stage after it advances;
  // the output stage advances when it is empty or out_ready is high.
  logic r_v1, r_v2;
  logic w_s1_adv, w_s2_adv, w_s3_adv;

  assign w_s3_adv = !out_valid || out_ready;
  assign w_s2_adv = !r_v2 || w_s3_adv;
  assign w_s1_adv = !r_v1 || w_s2_adv;
  assign in_ready = w_s1_adv;

  logic [WIDTH-1:0] r_a1, r_b1;
  logic             r_sgn1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1   <= 1'b0;
      r_a1   <= '0;
      r_b1   <= '0;
      r_sgn1 <= 1'b0;
    end else if (w_s1_adv) begin
      r_v1 <= in_valid;
      if (in_valid) begin
        r_a1   <= in_a;
        r_b1   <= in_b;
        r_sgn1 <= in_signed;
      end
    end
  end

  logic [PW-1:0] w_sum, w_carry;

  // Baugh-Wooley rows (cross-sign terms inverted, constant row adds 2^W + 2^(2W-1)),
  // then layers of row-wise 3:2 compressors, with a 2:2 on a leftover pair, until two rows remain.
  always_comb begin : wallace_tree
    logic [PW-1:0] red [NR];
    logic [PW-1:0] nxt [NR];
    logic          pp;
    int            n;
    int            m;
    for (int k = 0; k < NR; k++) begin
      red[k] = '0;
      nxt[k] = '0;
    end
    pp = 1'b0;
    n  = NR;
    m  = 0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp = r_a1[j] & r_b1[i];
        if (r_sgn1 && ((i == WIDTH - 1) != (j == WIDTH - 1))) pp = ~pp;
        red[i][i+j] = pp;
      end
    end
    red[WIDTH] = r_sgn1 ? ((PW'(1) << WIDTH) | (PW'(1) << (PW - 1))) : '0;
    for (int l = 0; l < MAX_LAYERS; l++) begin
      if (n > 2) begin
        m = 0;
        for (int k = 0; k < NR; k++) nxt[k] = '0;
        for (int g = 0; g < NR / 3; g++) begin
          if (3 * g + 2 < n) begin
            nxt[m]   = red[3*g] ^ red[3*g+1] ^ red[3*g+2];
            nxt[m+1] = ((red[3*g] & red[3*g+1]) | (red[3*g] & red[3*g+2]) |
                        (red[3*g+1] & red[3*g+2])) << 1;
            m = m + 2;
          end
        end
        if (n % 3 == 2) begin
          nxt[m]   = red[n-2] ^ red[n-1];
          nxt[m+1] = (red[n-2] & red[n-1]) << 1;
          m = m + 2;
        end else if (n % 3 == 1) begin
          nxt[m] = red[n-1];
          m = m + 1;
        end
        for (int k = 0; k < NR; k++) red[k] = nxt[k];
        n = m;
      end
    end
    w_sum   = red[0];
    w_carry = red[1];
  end

  logic [PW-1:0] r_sum2, r_carry2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2     <= 1'b0;
      r_sum2   <= '0;
      r_carry2 <= '0;
    end else if (w_s2_adv) begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r_sum2   <= w_sum;
        r_carry2 <= w_carry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_product <= '0;
    end else if (w_s3_adv) begin
      out_valid <= r_v2;
      if (r_v2) out_product <= r_sum2 + r_carry2;
    end
  end

`ifdef WALLACE_TAG_EN
  logic [TAG_W-1:0] r_tag1, r_tag2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag1  <= '0;
      r_tag2  <= '0;
      out_tag <= '0;
    end else begin
      if (w_s1_adv && in_valid) r_tag1 <= in_tag;
      if (w_s2_adv && r_v1) r_tag2 <= r_tag1;
      if (w_s3_adv && r_v2) out_tag <= r_tag2;
    end
  end
`else
  if (TAG_W < 1) begin : g_bad_tag_w
    $error("wallace_mult_pipe: TAG_W must be at least 1");
  end
`endif

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// Directed bench for wallace_mult_pipe: WIDTH=8 and WIDTH=4 instances, latency, backpressure, reset, sweeps.
// Tag checks are compiled in when WALLACE_TAG_EN is defined.
module tb_wallace_mult_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        v8, rdy8, s8, ov8, or8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        v4, rdy4, s4, ov4, or4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
`ifdef WALLACE_TAG_EN
  logic [3:0]  ti8, to8, ti4, to4;
`endif

  wallace_mult_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v8), .in_ready(rdy8), .in_a(a8), .in_b(b8), .in_signed(s8),
    .out_valid(ov8), .out_ready(or8), .out_product(p8)
`ifdef WALLACE_TAG_EN
    , .in_tag(ti8), .out_tag(to8)
`endif
  );

  wallace_mult_pipe #(.WIDTH(4), .TAG_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v4), .in_ready(rdy4), .in_a(a4), .in_b(b4), .in_signed(s4),
    .out_valid(ov4), .out_ready(or4), .out_product(p4)
`ifdef WALLACE_TAG_EN
    , .in_tag(ti4), .out_tag(to4)
`endif
  );

  int          n_vec = 0;
  int          n_fail = 0;
  logic        rand_rdy = 1'b0;
  logic [15:0] exp_q8[$];
  logic [7:0]  exp_q4[$];
  logic [3:0]  tag_q8[$];
  logic [15:0] mon_e8;
  logic [7:0]  mon_e4;
  logic [3:0]  mon_t8;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [15:0] sa, sb;
    if (s) begin
      sa = 16'($signed(a));
      sb = 16'($signed(b));
      return 16'(sa * sb);
    end
    return 16'({8'b0, a} * {8'b0, b});
  endfunction

  function automatic logic [7:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic s);
    logic signed [7:0] sa, sb;
    if (s) begin
      sa = 8'($signed(a));
      sb = 8'($signed(b));
      return 8'(sa * sb);
    end
    return 8'({4'b0, a} * {4'b0, b});
  endfunction

  // Scoreboard: every product leaving a DUT is matched against the head of its queue.
  always @(negedge clk) begin
    if (rst_n && ov8 && or8) begin
      if (exp_q8.size() == 0) begin
        n_vec++;
        n_fail++;
        $error("FAIL dut8_spurious: observed %h expected none", p8);
      end else begin
        mon_e8 = exp_q8.pop_front();
        mon_t8 = tag_q8.pop_front();
        chk("dut8_stream", 32'(p8), 32'(mon_e8));
`ifdef WALLACE_TAG_EN
        chk("dut8_tag", 32'(to8), 32'(mon_t8));
`endif
      end
    end
    if (rst_n && ov4 && or4) begin
      if (exp_q4.size() == 0) begin
        n_vec++;
        n_fail++;
        $error("FAIL dut4_spurious: observed %h expected none", p4);
      end else begin
        mon_e4 = exp_q4.pop_front();
        chk("dut4_stream", 32'(p4), 32'(mon_e4));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      or8 = 1'($urandom_range(0, 1));
      or4 = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [3:0] t, input logic [15:0] exp);
    bit ok;
    int cnt;
    a8 = a; b8 = b; s8 = s; v8 = 1'b1;
`ifdef WALLACE_TAG_EN
    ti8 = t;
`endif
    ok = 1'b0;
    cnt = 0;
    while (!ok && cnt < 200) begin
      @(negedge clk);
      ok = rdy8;
      tick();
      cnt++;
    end
    if (ok) begin
      exp_q8.push_back(exp);
      tag_q8.push_back(t);
    end else begin
      n_vec++;
      n_fail++;
      $error("FAIL send8_timeout: in_ready observed 0 expected 1 within 200 cycles");
    end
    v8 = 1'b0; a8 = 'x; b8 = 'x; s8 = 1'bx;
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic s, input logic [7:0] exp);
    bit ok;
    int cnt;
    a4 = a; b4 = b; s4 = s; v4 = 1'b1;
    ok = 1'b0;
    cnt = 0;
    while (!ok && cnt < 200) begin
      @(negedge clk);
      ok = rdy4;
      tick();
      cnt++;
    end
    if (ok) exp_q4.push_back(exp);
    else begin
      n_vec++;
      n_fail++;
      $error("FAIL send4_timeout: in_ready observed 0 expected 1 within 200 cycles");
    end
    v4 = 1'b0; a4 = 'x; b4 = 'x; s4 = 1'bx;
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while ((exp_q8.size() != 0 || exp_q4.size() != 0) && cnt < 4000) begin
      tick();
      cnt++;
    end
    if (exp_q8.size() != 0 || exp_q4.size() != 0) begin
      n_vec++;
      n_fail++;
      $error("FAIL drain_timeout: pending observed %0d/%0d expected 0/0", exp_q8.size(), exp_q4.size());
      exp_q8.delete();
      exp_q4.delete();
      tag_q8.delete();
    end
  endtask

  initial begin
    v8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; or8 = 1'b1;
    v4 = 1'b0; a4 = '0; b4 = '0; s4 = 1'b0; or4 = 1'b1;
`ifdef WALLACE_TAG_EN
    ti8 = '0; ti4 = '0;
`endif
    // Reset values
    #1 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(ov8), 32'd0);
    chk("rst_out_product", 32'(p8), 32'd0);
    chk("rst_out_valid_w4", 32'(ov4), 32'd0);
`ifdef WALLACE_TAG_EN
    chk("rst_out_tag", 32'(to8), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk("in_ready_after_reset", 32'(rdy8), 32'd1);

    // Unsigned 0xFF*0xFF, visible in the third cycle after it is presented
    send8(8'hFF, 8'hFF, 1'b0, 4'd0, 16'hFE01);
    chk("t1_valid_c1", 32'(ov8), 32'd0);
    tick();
    chk("t1_valid_c2", 32'(ov8), 32'd0);
    tick();
    chk("t1_valid_c3", 32'(ov8), 32'd1);
    chk("t1_product_c3", 32'(p8), 32'h0000FE01);
    drain();

    // Signed corners back to back, interleaved with unsigned
    send8(8'hFF, 8'hFF, 1'b1, 4'd1, 16'h0001);
    send8(8'h80, 8'h80, 1'b1, 4'd2, 16'h4000);
    send8(8'h80, 8'h80, 1'b0, 4'd3, 16'h4000);
    send8(8'h80, 8'h7F, 1'b1, 4'd4, 16'hC080);
    send8(8'h80, 8'h7F, 1'b0, 4'd5, 16'h3F80);
    send8(8'h7F, 8'h80, 1'b1, 4'd6, 16'hC080);
    send8(8'hFF, 8'h01, 1'b1, 4'd7, 16'hFFFF);
    send8(8'hFF, 8'h01, 1'b0, 4'd8, 16'h00FF);
    send8(8'h7F, 8'h7F, 1'b1, 4'd9, 16'h3F01);
    send8(8'h00, 8'h80, 1'b1, 4'd10, 16'h0000);
    drain();

    // Backpressure: out_ready low for 5 cycles while 6 operands are offered
    or8 = 1'b0;
    send8(8'd1, 8'd1, 1'b0, 4'd1, 16'd1);
    send8(8'd2, 8'd2, 1'b0, 4'd2, 16'd4);
    send8(8'd3, 8'd3, 1'b0, 4'd3, 16'd9);
    chk("t3_in_ready_full", 32'(rdy8), 32'd0);
    chk("t3_out_valid_full", 32'(ov8), 32'd1);
    chk("t3_product_full", 32'(p8), 32'd1);
    a8 = 8'd4; b8 = 8'd4; s8 = 1'b0; v8 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t3_stall_valid", 32'(ov8), 32'd1);
      chk("t3_stall_product", 32'(p8), 32'd1);
      chk("t3_stall_in_ready", 32'(rdy8), 32'd0);
    end
    or8 = 1'b1;
    send8(8'd4, 8'd4, 1'b0, 4'd4, 16'd16);
    send8(8'd5, 8'd5, 1'b0, 4'd5, 16'd25);
    send8(8'd6, 8'd6, 1'b0, 4'd6, 16'd36);
    drain();

    // Reset with three results in flight
    or8 = 1'b0;
    send8(8'd7, 8'd7, 1'b0, 4'd1, 16'h0031);
    send8(8'd9, 8'd9, 1'b0, 4'd2, 16'h0051);
    send8(8'd2, 8'd3, 1'b0, 4'd3, 16'h0006);
    chk("t4_full_before_reset", 32'(ov8), 32'd1);
    #2 rst_n = 1'b0;
    exp_q8.delete();
    tag_q8.delete();
    #1;
    chk("t4_async_valid", 32'(ov8), 32'd0);
    chk("t4_async_product", 32'(p8), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    or8 = 1'b1;
    chk("t4_after_release_valid", 32'(ov8), 32'd0);
    send8(8'd3, 8'd5, 1'b0, 4'd11, 16'h000F);
    chk("t4_valid_c1", 32'(ov8), 32'd0);
    tick();
    chk("t4_valid_c2", 32'(ov8), 32'd0);
    tick();
    chk("t4_valid_c3", 32'(ov8), 32'd1);
    chk("t4_product_c3", 32'(p8), 32'h0000000F);
    drain();

    // Sweeps under random out_ready: exhaustive WIDTH=4, strided plus corners WIDTH=8
    rand_rdy = 1'b1;
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          send4(4'(a), 4'(b), 1'(s), ref4(4'(a), 4'(b), 1'(s)));
    drain();
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 256; a += 17)
        for (int b = 0; b < 256; b++)
          send8(8'(a), 8'(b), 1'(s), 4'(b), ref8(8'(a), 8'(b), 1'(s)));
    for (int s = 0; s < 2; s++)
      for (int c = 0; c < 4; c++)
        for (int b = 0; b < 256; b++)
          send8(8'(8'h7E + c), 8'(b), 1'(s), 4'(b + c), ref8(8'(8'h7E + c), 8'(b), 1'(s)));
    drain();

`ifdef WALLACE_TAG_EN
    for (int t = 0; t < 16; t++)
      send8(8'(t * 13 + 5), 8'(200 - t * 7), 1'(t % 2), 4'(t), ref8(8'(t * 13 + 5), 8'(200 - t * 7), 1'(t % 2)));
    drain();
`endif
    rand_rdy = 1'b0;
    or8 = 1'b1;
    or4 = 1'b1;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
